// File: rtl/kamus_rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage vs. buffered long-latency returns, with starvation forcing.
// Optional macro KAMUS_RF_ARB_BYPASS_EN lets a result write straight through when the port and FIFO are idle.
module kamus_rf_wr_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wb_wr_en_i,
    input  logic [4:0]                    wb_rd_addr_i,
    input  logic [31:0]                   wb_data_i,
    output logic                          wb_stall_o,
    input  logic                          lu_valid_i,
    output logic                          lu_ready_o,
    input  logic [4:0]                    lu_rd_addr_i,
    input  logic [31:0]                   lu_data_i,
    output logic                          rf_wr_en_o,
    output logic [4:0]                    rf_rd_addr_o,
    output logic [31:0]                   rf_wr_data_o,
    output logic                          pending_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rd_mem_q   [FIFO_DEPTH];
    logic [4:0]    rd_mem_d   [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    starve_q, starve_d;

    logic          pending, full, force_grant;
    logic          push, pop, bypass;
    logic          rf_en, stall;
    logic [4:0]    rf_rd, head_rd;
    logic [31:0]   rf_data, head_data;

    assign pending     = (cnt_q != '0);
    assign full        = (cnt_q == CW'(FIFO_DEPTH));
    assign head_rd     = rd_mem_q[rd_ptr_q];
    assign head_data   = data_mem_q[rd_ptr_q];
    assign force_grant = pending && (starve_q == 4'(STARVE_LIMIT));

    // Port grant. Writes to x0 are consumed but never reach the regfile.
    always_comb begin
        rf_en   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        stall   = 1'b0;
        pop     = 1'b0;
        bypass  = 1'b0;
        if (force_grant) begin
            rf_en   = (head_rd != 5'd0);
            rf_rd   = head_rd;
            rf_data = head_data;
            stall   = wb_wr_en_i;
            pop     = 1'b1;
        end else if (wb_wr_en_i) begin
            rf_en   = (wb_rd_addr_i != 5'd0);
            rf_rd   = wb_rd_addr_i;
            rf_data = wb_data_i;
            // Older buffered value to the same register is dead once WB writes it.
            if (pending && (head_rd == wb_rd_addr_i) && (wb_rd_addr_i != 5'd0)) begin
                pop = 1'b1;
            end
        end else if (pending) begin
            rf_en   = (head_rd != 5'd0);
            rf_rd   = head_rd;
            rf_data = head_data;
            pop     = 1'b1;
        end
`ifdef KAMUS_RF_ARB_BYPASS_EN
        else if (lu_valid_i) begin
            rf_en   = (lu_rd_addr_i != 5'd0);
            rf_rd   = lu_rd_addr_i;
            rf_data = lu_data_i;
            bypass  = 1'b1;
        end
`endif
    end

    assign push = lu_valid_i && !full && !bypass;

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = lu_rd_addr_i;
            data_mem_d[wr_ptr_q] = lu_data_i;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Counter restarts whenever the head changes, so a forced stall never repeats back to back.
        if (!pending || pop) begin
            starve_d = 4'd0;
        end else if (starve_q < 4'(STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
        end
    end

    assign rf_wr_en_o    = rf_en && !rst_i;
    assign rf_rd_addr_o  = rf_rd;
    assign rf_wr_data_o  = rf_data;
    assign wb_stall_o    = stall && !rst_i;
    assign lu_ready_o    = !full && !rst_i;
    assign pending_o     = pending && !rst_i;
    assign pending_cnt_o = rst_i ? '0 : cnt_q;

endmodule
